// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Brief   : Multi-cycle word-organised data memory responder for the MEM stage
// Revision: 1.0
// ============================================================================
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        ReqValid,
   input  logic        ReqWrite,
   input  logic [31:0] ReqAddr,
   input  logic [31:0] ReqWData,
   input  logic [3:0]  ReqByteEn,
   output logic        ReqReady,
   output logic        RspValid,
   output logic [31:0] RspRData,
   output logic        RspErr,
   output logic        Stall
);

   localparam int          c_AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] c_DEPTH    = 32'(DEPTH_WORDS);
   localparam logic [3:0]  c_CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_WAIT = 2'd1;
   localparam logic [1:0] c_RESP = 2'd2;

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   logic        r_write;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic            w_in_idle;
   logic            w_accept;
   logic            w_do_access;
   logic            w_write;
   logic [31:0]     w_addr;
   logic [31:0]     w_wdata;
   logic [3:0]      w_be;
   logic            w_err;
   logic [c_AW-1:0] w_idx;
   logic            w_mem_we;

   // With zero latency the access happens at the acceptance edge, so the
   // live request inputs are used instead of the latched copy.
   always_comb begin
      w_in_idle   = (r_state == c_IDLE);
      w_accept    = ReqValid & w_in_idle;
      w_do_access = (w_accept & (LATENCY == 0)) | ((r_state == c_WAIT) & (r_cnt == 4'd0));
      w_write     = w_in_idle ? ReqWrite  : r_write;
      w_addr      = w_in_idle ? ReqAddr   : r_addr;
      w_wdata     = w_in_idle ? ReqWData  : r_wdata;
      w_be        = w_in_idle ? ReqByteEn : r_be;
      w_err       = (w_addr[1:0] != 2'b00) | ({2'b00, w_addr[31:2]} >= c_DEPTH);
      w_idx       = w_addr[c_AW+1:2];
      w_mem_we    = Rst_n & w_do_access & w_write & ~w_err;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state     <= c_IDLE;
         r_cnt       <= 4'd0;
         r_write     <= 1'b0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_be        <= 4'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  r_write <= ReqWrite;
                  r_addr  <= ReqAddr;
                  r_wdata <= ReqWData;
                  r_be    <= ReqByteEn;
                  if (LATENCY == 0) begin
                     r_state <= c_RESP;
                  end else begin
                     r_state <= c_WAIT;
                     r_cnt   <= c_CNT_INIT;
                  end
               end
            end
            c_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state <= c_RESP;
               end
            end
            c_RESP:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase

         if (w_do_access) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err | w_write) ? 32'd0 : r_mem[w_idx];
         end else if (r_state == c_RESP) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
         end
      end
   end

   // Storage is deliberately left out of reset; contents survive Rst_n.
   always_ff @(posedge Clk) begin
      if (w_mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
         end
      end
   end

   assign ReqReady = w_in_idle;
   assign Stall    = (r_state == c_WAIT) | (w_in_idle & ReqValid);
   assign RspValid = r_rsp_valid;
   assign RspRData = r_rsp_rdata;
   assign RspErr   = r_rsp_err;

endmodule
`default_nettype wire
